// File: rtl/text_cursor_ctrl.sv
// Write sequencer for port A of the character buffer: accepts bytes over valid/ready,
// tracks the cursor, decodes control characters and streams line/screen clears.
module text_cursor_ctrl #(
  parameter int unsigned COLS           = 80,
  parameter int unsigned ROWS           = 30,
  parameter logic [7:0]  FILL_CHAR      = 8'h20,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] vram_addr,
  output logic [7:0]  vram_data,
  output logic        vram_we,
  output logic [4:0]  cur_row,
  output logic [6:0]  cur_col,
  output logic        busy
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_ENTER = 8'h8D;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE      = 2'd1,
    CLR_LINE   = 2'd2,
    CLR_SCREEN = 2'd3
  } state_t;

  state_t     state;
  logic       init_done;
  logic       line_after_write;  // WRITE cycle of a wrapping printable, line clear follows
  logic [6:0] clr_col;
  logic [4:0] clr_row;

  logic       accept;
  logic       is_printable;
  logic [4:0] row_after;

  assign accept       = in_valid && in_ready;
  assign is_printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
  // Row advance wraps by compare, not by counter overflow (ROWS need not be a power of two)
  assign row_after    = (cur_row == LAST_ROW) ? 5'd0 : cur_row + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      init_done        <= 1'b0;
      line_after_write <= 1'b0;
      clr_col          <= 7'd0;
      clr_row          <= 5'd0;
      in_ready         <= 1'b0;
      vram_we          <= 1'b0;
      vram_addr        <= 12'd0;
      vram_data        <= 8'd0;
      cur_row          <= 5'd0;
      cur_col          <= 7'd0;
      busy             <= 1'b0;
    end else begin
      vram_we <= 1'b0;
      if (!init_done) begin
        init_done <= 1'b1;
        if (CLEAR_ON_RESET) begin
          state     <= CLR_SCREEN;
          busy      <= 1'b1;
          clr_row   <= 5'd0;
          clr_col   <= 7'd0;
          vram_we   <= 1'b1;
          vram_addr <= 12'd0;
          vram_data <= FILL_CHAR;
        end else begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              // Commands without a clear still spend one WRITE cycle so in_ready drops
              in_ready         <= 1'b0;
              line_after_write <= 1'b0;
              state            <= WRITE;
              if (is_printable) begin
                vram_we   <= 1'b1;
                vram_addr <= {cur_row, cur_col};
                vram_data <= in_data;
                if (cur_col == LAST_COL) begin
                  cur_col          <= 7'd0;
                  cur_row          <= row_after;
                  line_after_write <= 1'b1;
                end else begin
                  cur_col <= cur_col + 7'd1;
                end
              end else begin
                case (in_data)
                  CH_CR: cur_col <= 7'd0;
                  CH_LF, CH_ENTER: begin
                    cur_row <= row_after;
                    if (in_data == CH_ENTER) cur_col <= 7'd0;
                    state     <= CLR_LINE;
                    busy      <= 1'b1;
                    clr_col   <= 7'd0;
                    vram_we   <= 1'b1;
                    vram_addr <= {row_after, 7'd0};
                    vram_data <= FILL_CHAR;
                  end
                  CH_BS: begin
                    if (cur_col != 7'd0) begin
                      cur_col   <= cur_col - 7'd1;
                      vram_we   <= 1'b1;
                      vram_addr <= {cur_row, cur_col - 7'd1};
                      vram_data <= FILL_CHAR;
                    end
                  end
                  CH_FF: begin
                    cur_row   <= 5'd0;
                    cur_col   <= 7'd0;
                    state     <= CLR_SCREEN;
                    busy      <= 1'b1;
                    clr_row   <= 5'd0;
                    clr_col   <= 7'd0;
                    vram_we   <= 1'b1;
                    vram_addr <= 12'd0;
                    vram_data <= FILL_CHAR;
                  end
                  default: ;
                endcase
              end
            end
          end

          WRITE: begin
            if (line_after_write) begin
              line_after_write <= 1'b0;
              state            <= CLR_LINE;
              busy             <= 1'b1;
              clr_col          <= 7'd0;
              vram_we          <= 1'b1;
              vram_addr        <= {cur_row, 7'd0};
              vram_data        <= FILL_CHAR;
            end else begin
              state    <= IDLE;
              in_ready <= 1'b1;
            end
          end

          CLR_LINE: begin
            if (clr_col == LAST_COL) begin
              state    <= IDLE;
              busy     <= 1'b0;
              in_ready <= 1'b1;
            end else begin
              clr_col   <= clr_col + 7'd1;
              vram_we   <= 1'b1;
              vram_addr <= {cur_row, clr_col + 7'd1};
            end
          end

          CLR_SCREEN: begin
            if (clr_col == LAST_COL) begin
              if (clr_row == LAST_ROW) begin
                state    <= IDLE;
                busy     <= 1'b0;
                in_ready <= 1'b1;
              end else begin
                clr_col   <= 7'd0;
                clr_row   <= clr_row + 5'd1;
                vram_we   <= 1'b1;
                vram_addr <= {clr_row + 5'd1, 7'd0};
              end
            end else begin
              clr_col   <= clr_col + 7'd1;
              vram_we   <= 1'b1;
              vram_addr <= {clr_row, clr_col + 7'd1};
            end
          end

          default: begin
            state    <= IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Self-checking bench for text_cursor_ctrl: vector table, directed corner sequences
// and randomized bytes compared against a write-list model of the cursor rules.
module tb_text_cursor_ctrl;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam logic [7:0] FILL = 8'h20;
  localparam int BOUND = 6000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] vram_addr;
  logic [7:0]  vram_data;
  logic        vram_we;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;
  logic        busy;

  text_cursor_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .FILL_CHAR(FILL), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .vram_addr(vram_addr), .vram_data(vram_data), .vram_we(vram_we),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         row;
    int         col;
    int         writes;
    int         first_wr;
    int         low;
  } vec_t;

  vec_t vecs[15];

  int n_tests = 0;
  int n_fail = 0;
  int bad_addr = 0;
  logic [19:0] log_q[$];
  logic [19:0] exp_q[$];
  int m_row, m_col, exp_low, exp_clear;
  int low_cycles, busy_cycles;

  // Every write as {addr, data}; addresses outside the visible grid are tallied
  always @(negedge clk) begin
    if (rst_n && vram_we) begin
      log_q.push_back({vram_addr, vram_data});
      if (vram_addr[6:0] >= 7'(COLS) || vram_addr[11:7] >= 5'(ROWS)) bad_addr++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [19:0] pack(input int r, input int c, input logic [7:0] d);
    logic [4:0] r5;
    logic [6:0] c7;
    r5 = r[4:0];
    c7 = c[6:0];
    return {r5, c7, d};
  endfunction

  task automatic add_line(input int r);
    for (int c = 0; c < COLS; c++) exp_q.push_back(pack(r, c, FILL));
  endtask

  // Reference: list of buffer writes and resulting cursor for one accepted byte
  task automatic model_step(input logic [7:0] b);
    exp_q.delete();
    exp_clear = 0;
    exp_low = 1;
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back(pack(m_row, m_col, b));
      if (m_col < COLS - 1) m_col++;
      else begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        add_line(m_row);
        exp_clear = COLS;
        exp_low = 1 + COLS;
      end
    end else begin
      case (b)
        8'h0D: m_col = 0;
        8'h0A: begin
          m_row = (m_row + 1) % ROWS;
          add_line(m_row);
          exp_clear = COLS; exp_low = COLS;
        end
        8'h8D: begin
          m_row = (m_row + 1) % ROWS;
          m_col = 0;
          add_line(m_row);
          exp_clear = COLS; exp_low = COLS;
        end
        8'h08: begin
          if (m_col > 0) begin
            m_col--;
            exp_q.push_back(pack(m_row, m_col, FILL));
          end
        end
        8'h0C: begin
          m_row = 0; m_col = 0;
          for (int r = 0; r < ROWS; r++) add_line(r);
          exp_clear = ROWS * COLS; exp_low = ROWS * COLS;
        end
        default: ;
      endcase
    end
  endtask

  // Called at a negedge; returns at the negedge where in_ready is back high
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    while (!in_ready && guard < BOUND) begin
      @(negedge clk);
      guard++;
    end
    check("ready before send", int'(in_ready), 1);
    log_q.delete();
    in_data = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    low_cycles = 0;
    busy_cycles = 0;
    while (!in_ready && low_cycles < BOUND) begin
      low_cycles++;
      if (busy) busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic do_step(input logic [7:0] b, input string tag);
    int mism;
    model_step(b);
    send_byte(b);
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= log_q.size() || log_q[i] !== exp_q[i]) mism++;
    check($sformatf("%s writes", tag), log_q.size(), exp_q.size());
    check($sformatf("%s stream", tag), mism, 0);
    check($sformatf("%s row", tag), int'(cur_row), m_row);
    check($sformatf("%s col", tag), int'(cur_col), m_col);
    check($sformatf("%s ready-low", tag), low_cycles, exp_low);
    check($sformatf("%s busy", tag), busy_cycles, exp_clear);
    $display("[TB] %s byte=%02h -> cursor (%0d,%0d) writes=%0d", tag, b, cur_row, cur_col, log_q.size());
  endtask

  initial begin
    int n, busy_seen, bad_data, wcnt, guard;
    logic [19:0] last;
    logic [7:0] rb;
    int k;

    vecs[0]  = '{8'h41, 0, 1, 1,    'h00041, 1};
    vecs[1]  = '{8'h42, 0, 2, 1,    'h00142, 1};
    vecs[2]  = '{8'h0D, 0, 0, 0,    0,       1};
    vecs[3]  = '{8'h07, 0, 0, 0,    0,       1};
    vecs[4]  = '{8'h08, 0, 0, 0,    0,       1};
    vecs[5]  = '{8'h0A, 1, 0, 80,   'h08020, 80};
    vecs[6]  = '{8'h8D, 2, 0, 80,   'h10020, 80};
    vecs[7]  = '{8'h43, 2, 1, 1,    'h10043, 1};
    vecs[8]  = '{8'h44, 2, 2, 1,    'h10144, 1};
    vecs[9]  = '{8'h45, 2, 3, 1,    'h10245, 1};
    vecs[10] = '{8'h46, 2, 4, 1,    'h10346, 1};
    vecs[11] = '{8'h47, 2, 5, 1,    'h10447, 1};
    vecs[12] = '{8'h08, 2, 4, 1,    'h10420, 1};
    vecs[13] = '{8'hFF, 2, 4, 0,    0,       1};
    vecs[14] = '{8'h0C, 0, 0, 2400, 'h00020, 2400};

    // Reset values
    repeat (3) @(negedge clk);
    check("reset in_ready", int'(in_ready), 0);
    check("reset vram_we", int'(vram_we), 0);
    check("reset vram_addr", int'(vram_addr), 0);
    check("reset vram_data", int'(vram_data), 0);
    check("reset cur_row", int'(cur_row), 0);
    check("reset cur_col", int'(cur_col), 0);
    check("reset busy", int'(busy), 0);

    // Clear-on-reset
    log_q.delete();
    rst_n = 1'b1;
    n = 0; busy_seen = 0;
    while (!in_ready && n < BOUND) begin
      @(negedge clk);
      n++;
      if (busy) busy_seen++;
    end
    bad_data = 0;
    foreach (log_q[i]) if (log_q[i][7:0] !== FILL) bad_data++;
    last = (log_q.size() > 0) ? log_q[log_q.size() - 1] : 20'h0;
    check("init clear writes", log_q.size(), 2400);
    check("init clear data", bad_data, 0);
    check("init clear last", int'(last), 'hECF20);
    check("init clear busy cycles", busy_seen, 2400);
    check("init busy after", int'(busy), 0);
    check("init in_ready", int'(in_ready), 1);
    check("init row", int'(cur_row), 0);
    check("init col", int'(cur_col), 0);
    $display("[TB] reset clear: %0d writes, last %05h", log_q.size(), last);

    // Vector table
    m_row = 0; m_col = 0;
    for (int i = 0; i < 15; i++) begin
      do_step(vecs[i].data, $sformatf("vec%0d", i));
      check($sformatf("vec%0d tbl row", i), int'(cur_row), vecs[i].row);
      check($sformatf("vec%0d tbl col", i), int'(cur_col), vecs[i].col);
      check($sformatf("vec%0d tbl writes", i), log_q.size(), vecs[i].writes);
      check($sformatf("vec%0d tbl ready-low", i), low_cycles, vecs[i].low);
      if (vecs[i].writes > 0 && log_q.size() > 0)
        check($sformatf("vec%0d tbl first write", i), int'(log_q[0]), vecs[i].first_wr);
    end

    // Wrap from (3,79)
    do_step(8'h0C, "pos ff");
    for (int i = 0; i < 3; i++) do_step(8'h8D, "pos enter");
    for (int i = 0; i < 79; i++) do_step(8'h61 + 8'(i % 26), "pos char");
    do_step(8'h5A, "wrap");
    check("wrap first write", (log_q.size() > 0) ? int'(log_q[0]) : -1, 'h1CF5A);
    check("wrap last clear", (log_q.size() > 80) ? int'(log_q[80]) : -1, 'h24F20);
    check("wrap row", int'(cur_row), 4);
    check("wrap col", int'(cur_col), 0);

    // LF wrap from (29,10), then Enter
    do_step(8'h0C, "pos ff");
    for (int i = 0; i < 10; i++) do_step(8'h30 + 8'(i), "pos digit");
    for (int i = 0; i < 29; i++) do_step(8'h0A, "pos lf");
    do_step(8'h0A, "lf wrap");
    check("lf wrap first", (log_q.size() > 0) ? int'(log_q[0]) : -1, 'h00020);
    check("lf wrap last", (log_q.size() > 79) ? int'(log_q[79]) : -1, 'h04F20);
    check("lf wrap row", int'(cur_row), 0);
    check("lf wrap col", int'(cur_col), 10);
    do_step(8'h8D, "enter");
    check("enter first", (log_q.size() > 0) ? int'(log_q[0]) : -1, 'h08020);
    check("enter row", int'(cur_row), 1);
    check("enter col", int'(cur_col), 0);

    // Reset mid screen-clear with in_valid held
    in_data = 8'h0C;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_data = 8'h51;
    wcnt = vram_we ? 1 : 0;
    guard = 0;
    while (wcnt < 1000 && guard < BOUND) begin
      @(negedge clk);
      guard++;
      if (vram_we) wcnt++;
    end
    check("abort write count", wcnt, 1000);
    rst_n = 1'b0;
    #1;
    check("abort in_ready", int'(in_ready), 0);
    check("abort vram_we", int'(vram_we), 0);
    check("abort vram_addr", int'(vram_addr), 0);
    check("abort busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wcnt = 0; guard = 0;
    while (!in_ready && guard < BOUND) begin
      @(negedge clk);
      guard++;
      if (vram_we) wcnt++;
    end
    check("restart clear writes", wcnt, 2400);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("held Q we", int'(vram_we), 1);
    check("held Q addr", int'(vram_addr), 0);
    check("held Q data", int'(vram_data), 'h51);
    wcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (vram_we) wcnt++;
    end
    check("held Q single", wcnt, 0);
    check("held Q col", int'(cur_col), 1);
    check("held Q ready", int'(in_ready), 1);
    $display("[TB] abort/restart: Q written once, cursor (%0d,%0d)", cur_row, cur_col);

    // Randomized bytes against the model
    m_row = 0; m_col = 1;
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 99);
      if (k < 60) rb = 8'($urandom_range(32, 126));
      else if (k < 67) rb = 8'h0D;
      else if (k < 74) rb = 8'h0A;
      else if (k < 79) rb = 8'h8D;
      else if (k < 90) rb = 8'h08;
      else if (k < 91) rb = 8'h0C;
      else rb = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_step(rb, $sformatf("rnd%0d", i));
    end

    check("address range", bad_addr, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
